// File: rtl/uart_tx_queue.sv
// Transmit byte queue: circular FIFO feeding a UART transmitter one byte per tx_start/tx_done handshake.
// Latency: a byte written into an empty, idle queue produces tx_start on the second edge after the write.
// Backpressure: writes into a full queue are dropped and set sticky overflow; optional almost_full via UART_TXQ_ALMOST_FULL_EN.
module uart_tx_queue #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      tx_data,
    input  logic                   tx_done,
    output logic                   busy,
    output logic                   almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT_DONE
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    state_t            state;
    state_t            state_nxt;
    logic              tx_start_nxt;
    logic              busy_nxt;
    logic [DATA_W-1:0] tx_data_nxt;
    logic              pop;
    logic              wr_acc;
    logic [CW-1:0]     count_nxt;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    // A pop in the same cycle frees the slot the write lands in.
    assign wr_acc    = wr_en & (~full | pop);
    assign count_nxt = count + CW'(wr_acc) - CW'(pop);

    always_comb begin
        state_nxt    = state;
        tx_start_nxt = 1'b0;
        busy_nxt     = busy;
        tx_data_nxt  = tx_data;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    tx_data_nxt  = mem[rd_ptr];
                    tx_start_nxt = 1'b1;
                    busy_nxt     = 1'b1;
                    state_nxt    = ARM;
                end
            end
            ARM: begin
                // Wait for tx_done to drop so a done level left over from the last frame is not taken as completion.
                if (!tx_done) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_start <= tx_start_nxt;
            tx_data  <= tx_data_nxt;
            busy     <= busy_nxt;
            count    <= count_nxt;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

`ifdef UART_TXQ_ALMOST_FULL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_nxt >= CW'(AF_LEVEL));
        end
    end
`else
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a transmitter model returning tx_done after a programmable delay.
module tb_uart_tx_queue;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   wr_en;
    logic [DATA_W-1:0]      wr_data;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   tx_start;
    logic [DATA_W-1:0]      tx_data;
    logic                   tx_done;
    logic                   busy;
    logic                   almost_full;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sent_q[$];
    int          start_cnt = 0;
    bit          auto_en = 1'b0;
    int          dly = 20;
    int          hold = 1;
    logic        man_done = 1'b0;
    logic        resp_done = 1'b0;

    assign tx_done = auto_en ? resp_done : man_done;

    uart_tx_queue #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .busy       (busy),
        .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transmitter model: raise done dly cycles after each start, hold it for hold cycles.
    initial begin : responder
        int cnt;
        int hcnt;
        cnt  = 0;
        hcnt = 0;
        forever begin
            @(negedge clk);
            if (!auto_en) begin
                cnt       = 0;
                hcnt      = 0;
                resp_done = 1'b0;
            end else begin
                if (hcnt > 0) begin
                    hcnt = hcnt - 1;
                    if (hcnt == 0) resp_done = 1'b0;
                end
                if (tx_start === 1'b1) begin
                    cnt = dly;
                end else if (cnt > 0) begin
                    cnt = cnt - 1;
                    if (cnt == 0) begin
                        resp_done = 1'b1;
                        hcnt      = hold;
                    end
                end
            end
        end
    end

    // Records every start and watches start/busy exclusivity and tx_data stability.
    initial begin : monitor
        logic       prev_busy;
        logic [7:0] held;
        prev_busy = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                checks++;
                if (prev_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL start_while_busy: busy before start=%b, required 0", prev_busy);
                end
                sent_q.push_back(tx_data);
                start_cnt++;
                held = tx_data;
            end else if (busy === 1'b1) begin
                checks++;
                if (tx_data !== held) begin
                    errors++;
                    $display("FAIL tx_data_stable: got %h, required %h", tx_data, held);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; man_done = 1'b0; auto_en = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b, required 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b, required 0", full); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b, required 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b, required 0", almost_full); end
        tick();
    endtask

    task automatic test_single();
        sent_q.delete(); start_cnt = 0;
        auto_en = 1'b1; dly = 20; hold = 1;
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count_after_write: got %0d, required 1", count); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_after_write: got %b, required 0", empty); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b, required 0", tx_start); end
        tick();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b, required 1", tx_start); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data: got %h, required a5", tx_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, required 1", busy); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d, required 0", count); end
        tick();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b, required 0", tx_start); end
        for (int c = 0; c < 100 && busy !== 1'b0; c++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b, required 0 within 100 cycles", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_end: got %b, required 1", empty); end
        repeat (5) tick();
        checks++; if (start_cnt !== 1) begin errors++; $display("FAIL single_start_count: got %0d, required 1", start_cnt); end
        checks++;
        if (sent_q.size() != 1) begin errors++; $display("FAIL single_sent_size: got %0d, required 1", sent_q.size()); end
        else if (sent_q[0] !== 8'hA5) begin errors++; $display("FAIL single_sent_byte: got %h, required a5", sent_q[0]); end
    endtask

    task automatic test_burst();
        sent_q.delete(); start_cnt = 0;
        auto_en = 1'b0; man_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        // The first byte was popped right away, so one slot is free.
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL burst_count: got %0d, required 15", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL burst_full: got %b, required 0", full); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL burst_busy: got %b, required 1", busy); end
        man_done = 1'b1; tick(); man_done = 1'b0;
        auto_en = 1'b1; dly = 3; hold = 1;
        for (int c = 0; c < 600 && !(start_cnt == 16 && busy === 1'b0); c++) tick();
        repeat (5) tick();
        checks++; if (start_cnt !== 16) begin errors++; $display("FAIL burst_start_count: got %0d, required 16", start_cnt); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL burst_empty_end: got %b, required 1", empty); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= sent_q.size()) begin errors++; $display("FAIL burst_order[%0d]: missing, required %h", i, 8'(i + 1)); end
            else if (sent_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_order[%0d]: got %h, required %h", i, sent_q[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_overflow();
        sent_q.delete(); start_cnt = 0;
        auto_en = 1'b0; man_done = 1'b0;
        wr_en = 1'b1; wr_data = 8'h55; tick(); wr_en = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL ovf_stall: busy=%b count=%0d, required busy=1 count=0", busy, count); end
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(32'h20 + i);
            tick();
            if (i == 10) begin
                checks++; if (count !== 5'd11) begin errors++; $display("FAIL ovf_count11: got %0d, required 11", count); end
                checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL af_at_11: got %b, required 0", almost_full); end
            end
            if (i == 11) begin
                checks++;
`ifdef UART_TXQ_ALMOST_FULL_EN
                if (almost_full !== 1'b1) begin errors++; $display("FAIL af_at_12: got %b, required 1", almost_full); end
`else
                if (almost_full !== 1'b0) begin errors++; $display("FAIL af_disabled: got %b, required 0", almost_full); end
`endif
            end
            if (i == 15) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b, required 1", full); end
                checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count16: got %0d, required 16", count); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b, required 0", overflow); end
            end
            if (i == 16) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", overflow); end
                checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count_hold: got %0d, required 16", count); end
            end
        end
        wr_en = 1'b0;
        repeat (3) tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
        man_done = 1'b1; tick(); man_done = 1'b0;
        checks++; if (busy !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL ovf_release: busy=%b full=%b, required busy=0 full=1", busy, full); end
        // Write into a full queue on the pop cycle: accepted, count stays at DEPTH.
        wr_en = 1'b1; wr_data = 8'h31;
        auto_en = 1'b1; dly = 3; hold = 1;
        tick();
        wr_en = 1'b0;
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h20) begin errors++; $display("FAIL ovf_pop: start=%b data=%h, required start=1 data=20", tx_start, tx_data); end
        checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL full_pop_write: count=%0d full=%b, required 16 and 1", count, full); end
        for (int c = 0; c < 1000 && !(start_cnt == 18 && busy === 1'b0); c++) tick();
        repeat (5) tick();
        checks++; if (start_cnt !== 18) begin errors++; $display("FAIL ovf_start_count: got %0d, required 18", start_cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky_end: got %b, required 1", overflow); end
        checks++;
        if (sent_q.size() != 18) begin errors++; $display("FAIL ovf_sent_size: got %0d, required 18", sent_q.size()); end
        else begin
            logic [7:0] exp;
            int         bad;
            bad = 0;
            for (int i = 0; i < 18; i++) begin
                exp = (i == 0) ? 8'h55 : (i == 17) ? 8'h31 : 8'(32'h1F + i);
                if (sent_q[i] !== exp) begin
                    bad++;
                    $display("FAIL ovf_order[%0d]: got %h, required %h", i, sent_q[i], exp);
                end
            end
            if (bad != 0) errors++;
        end
    endtask

    task automatic test_level_done();
        sent_q.delete(); start_cnt = 0;
        auto_en = 1'b1; dly = 8; hold = 5;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(32'h61 + i);
            tick();
        end
        wr_en = 1'b0;
        for (int c = 0; c < 300 && !(start_cnt == 3 && busy === 1'b0); c++) tick();
        repeat (20) tick();
        checks++; if (start_cnt !== 3) begin errors++; $display("FAIL level_start_count: got %0d, required 3", start_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL level_busy_end: got %b, required 0", busy); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= sent_q.size()) begin errors++; $display("FAIL level_order[%0d]: missing", i); end
            else if (sent_q[i] !== 8'(32'h61 + i)) begin errors++; $display("FAIL level_order[%0d]: got %h, required %h", i, sent_q[i], 8'(32'h61 + i)); end
        end
    endtask

    task automatic test_reset_mid_and_wrap();
        sent_q.delete(); start_cnt = 0;
        auto_en = 1'b0; man_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(32'h71 + i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        checks++; if (busy !== 1'b1 || count !== 5'd4) begin errors++; $display("FAIL mid_pre: busy=%b count=%0d, required 1 and 4", busy, count); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || overflow !== 1'b0 ||
            tx_start !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: empty=%b full=%b count=%0d ovf=%b start=%b data=%h busy=%b af=%b, required 1 0 0 0 0 00 0 0",
                     empty, full, count, overflow, tx_start, tx_data, busy, almost_full);
        end
        repeat (10) tick();
        checks++; if (start_cnt !== 1) begin errors++; $display("FAIL mid_no_start: got %0d starts, required 1", start_cnt); end
        sent_q.delete(); start_cnt = 0;
        auto_en = 1'b1; dly = 2; hold = 1;
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b0;
            for (int c = 0; c < 50 && full === 1'b1; c++) tick();
            wr_en = 1'b1; wr_data = 8'(32'h80 + i);
            tick();
        end
        wr_en = 1'b0;
        for (int c = 0; c < 2000 && !(start_cnt == 40 && busy === 1'b0); c++) tick();
        repeat (5) tick();
        checks++; if (start_cnt !== 40) begin errors++; $display("FAIL wrap_start_count: got %0d, required 40", start_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %b, required 0", overflow); end
        checks++;
        if (sent_q.size() != 40) begin errors++; $display("FAIL wrap_sent_size: got %0d, required 40", sent_q.size()); end
        else begin
            int bad;
            bad = 0;
            for (int i = 0; i < 40; i++) begin
                if (sent_q[i] !== 8'(32'h80 + i)) begin
                    bad++;
                    $display("FAIL wrap_order[%0d]: got %h, required %h", i, sent_q[i], 8'(32'h80 + i));
                end
            end
            if (bad != 0) errors++;
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = '0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_level_done();
        test_reset_mid_and_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
